fpu_fcsr_wb: RTL and testbench

- Downstream stage of the single-precision FP adder datapath. Consumes its result word and exception flags (NV from invalid, NX from inexact; DZ/OF/UF from future FP units).
- Buffers results in a 2-entry skid FIFO toward the integer/FP register-file writeback.
- Owns the architectural fcsr (fflags sticky bits and frm), with a CSR read/modify port for Zicsr instructions.

---
 rtl/fpu_pkg.sv | 45 ++++
 rtl/fpu_fcsr_wb_if.sv | 28 ++
 rtl/fpu_result_fifo.sv | 89 ++++++++
 rtl/fpu_fcsr_wb.sv | 100 ++++++++++
 tb/tb_fpu_fcsr_wb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP result writeback / fcsr block.
//   - fflags bit positions inside the 5-bit accrued-exception field
//   - Zicsr addresses of the FP CSRs
//   - CSR operation encoding
//   - rounding-mode encodings
//   - csr_apply: applies a write/set/clear operation to a field value
package fpu_pkg;

  localparam int NV_BIT = 4;  // invalid operation
  localparam int DZ_BIT = 3;  // divide by zero
  localparam int OF_BIT = 2;  // overflow
  localparam int UF_BIT = 1;  // underflow
  localparam int NX_BIT = 0;  // inexact

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Result of a CSR operation on one field; read-only leaves it untouched.
  function automatic logic [7:0] csr_apply(csr_op_e op, logic [7:0] cur, logic [7:0] src);
    logic [7:0] res;
    res = cur;
    case (op)
      CSR_WRITE: res = src;
      CSR_SET:   res = cur | src;
      CSR_CLEAR: res = cur & ~src;
      default:   res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fpu_fcsr_wb_if.sv
// Result handshake bundle between the FP adder, this writeback stage and
// the register-file writeback port.
//   in_*  : upstream result channel (valid/ready, rd, data, exception flags)
//   wb_*  : downstream writeback channel (valid/ready, rd, data)
// slave  = the writeback stage; master = its environment.
interface fpu_fcsr_wb_if #(
  parameter int FLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [FLEN-1:0] in_data;
  logic [4:0]      in_flags;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [FLEN-1:0] wb_data;

  modport slave (
    input  in_valid, in_rd, in_data, in_flags, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data
  );

  modport master (
    output in_valid, in_rd, in_data, in_flags, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/fpu_result_fifo.sv
// DEPTH-entry valid/ready buffer of {rd,data} with synchronous flush.
//   CLK, RSTn          : clock, asynchronous active-low reset
//   flush              : drop all buffered entries and the incoming one
//   in_valid/in_ready  : upstream handshake, in_ready from registered count
//   in_rd, in_data     : entry written on push
//   push               : accepted-entry strobe (used for flag accumulation)
//   wb_valid/wb_ready  : downstream handshake
//   wb_rd, wb_data     : head entry; holds the last popped head when empty
module fpu_result_fifo #(
  parameter int FLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [FLEN-1:0] in_data,
  output logic            push,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [FLEN-1:0] wb_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [4:0]      rd_mem [DEPTH];
  logic [FLEN-1:0] data_mem [DEPTH];
  logic [4:0]      last_rd_reg;
  logic [FLEN-1:0] last_data_reg;
  logic            pop;

  assign in_ready = (count_reg != CW'(DEPTH));
  assign wb_valid = (count_reg != '0);
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = wb_valid & wb_ready & ~flush;

  // When empty the slot under rd_ptr may be stale, so present the last
  // popped head instead to keep the outputs stable and X-free.
  assign wb_rd   = wb_valid ? rd_mem[rd_ptr_reg]   : last_rd_reg;
  assign wb_data = wb_valid ? data_mem[rd_ptr_reg] : last_data_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          rd_mem[gi]   <= '0;
          data_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          rd_mem[gi]   <= in_rd;
          data_mem[gi] <= in_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      last_rd_reg   <= '0;
      last_data_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PW'(1);
        last_rd_reg   <= rd_mem[rd_ptr_reg];
        last_data_reg <= data_mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fpu_fcsr_wb.sv
// Writeback stage of the single-precision FP adder datapath: buffers
// results toward register-file writeback and owns the fcsr (fflags + frm).
//   CLK, RSTn   : clock, asynchronous active-low reset
//   bus         : in_* result channel and wb_* writeback channel
//   flush       : discard buffered and incoming results (fflags kept)
//   csr_en/op/addr/wdata : Zicsr access (read/write/set/clear)
//   csr_rdata   : pre-update value of the addressed CSR, zero-extended
//   csr_illegal : access to an address other than fflags/frm/fcsr
//   frm         : current rounding mode
module fpu_fcsr_wb
  import fpu_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RSTn,
  fpu_fcsr_wb_if.slave       bus,
  input  logic               flush,
  input  logic               csr_en,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  output logic [2:0]         frm
);

  logic       push;
  logic [4:0] fflags_reg, fflags_next, fflags_csr;
  logic [2:0] frm_reg, frm_next;
  logic       csr_legal, csr_upd, touch_ff, touch_rm;
  logic [2:0] rm_src;
  logic [7:0] ff_res, rm_res;
  logic       unused_wdata;

  fpu_result_fifo #(
    .FLEN  (FLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .flush    (flush),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_rd    (bus.in_rd),
    .in_data  (bus.in_data),
    .push     (push),
    .wb_valid (bus.wb_valid),
    .wb_ready (bus.wb_ready),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data)
  );

  assign unused_wdata = ^csr_wdata[31:8];

  assign csr_legal   = (csr_addr == CSR_FFLAGS) || (csr_addr == CSR_FRM) ||
                       (csr_addr == CSR_FCSR);
  assign csr_illegal = csr_en & ~csr_legal;
  assign csr_upd     = csr_en & csr_legal & (csr_op != CSR_READ);
  assign touch_ff    = (csr_addr == CSR_FFLAGS) || (csr_addr == CSR_FCSR);
  assign touch_rm    = (csr_addr == CSR_FRM)    || (csr_addr == CSR_FCSR);
  // frm sits at bit 0 when addressed alone, at [7:5] inside fcsr.
  assign rm_src      = (csr_addr == CSR_FRM) ? csr_wdata[2:0] : csr_wdata[7:5];

  assign ff_res = csr_apply(csr_op_e'(csr_op), {3'b0, fflags_reg}, {3'b0, csr_wdata[4:0]});
  assign rm_res = csr_apply(csr_op_e'(csr_op), {5'b0, frm_reg}, {5'b0, rm_src});

  always_comb begin
    fflags_csr  = fflags_reg;
    frm_next    = frm_reg;
    if (csr_upd && touch_ff) fflags_csr = ff_res[4:0];
    if (csr_upd && touch_rm) frm_next   = rm_res[2:0];
    // The CSR op is older than a same-cycle push, so flags OR on top of it.
    fflags_next = fflags_csr | (push ? bus.in_flags : 5'b0);
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_FFLAGS: csr_rdata = {27'b0, fflags_reg};
      CSR_FRM:    csr_rdata = {29'b0, frm_reg};
      CSR_FCSR:   csr_rdata = {24'b0, frm_reg, fflags_reg};
      default:    csr_rdata = '0;
    endcase
  end

  assign frm = frm_reg;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fflags_reg <= '0;
      frm_reg    <= RM_RNE;
    end else begin
      fflags_reg <= fflags_next;
      frm_reg    <= frm_next;
    end
  end

endmodule

// File: tb/tb_fpu_fcsr_wb.sv
module tb_fpu_fcsr_wb;
  import fpu_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        flush = 1'b0;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'd0;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [2:0]  frm;

  fpu_fcsr_wb_if #(.FLEN(32)) bus ();

  fpu_fcsr_wb #(.FLEN(32), .DEPTH(2)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .bus         (bus),
    .flush       (flush),
    .csr_en      (csr_en),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .frm         (frm)
  );

  always #5 CLK = ~CLK;

  // Reference model: an ordered queue of {rd,data} (capacity 2) and the
  // 8-bit fcsr image {frm,fflags}.
  logic [36:0] q[$];
  int          fcsr_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit iv, input logic [4:0] rd, input logic [31:0] data,
                       input logic [4:0] fl, input bit wr, input bit fs, input bit ce,
                       input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    bus.in_valid = iv; bus.in_rd = rd; bus.in_data = data; bus.in_flags = fl;
    bus.wb_ready = wr; flush = fs; csr_en = ce; csr_op = op; csr_addr = addr;
    csr_wdata = wd;
  endtask

  function automatic int exp_rdata(input logic [11:0] a);
    if (a == 12'h001) return fcsr_m % 32;
    if (a == 12'h002) return fcsr_m / 32;
    if (a == 12'h003) return fcsr_m;
    return 0;
  endfunction

  task automatic check_outputs();
    int sz = q.size();
    chk("in_ready", bus.in_ready, (sz < 2));
    chk("wb_valid", bus.wb_valid, (sz > 0));
    if (sz > 0) begin
      chk("wb_rd", bus.wb_rd, q[0][36:32]);
      chk("wb_data", bus.wb_data, q[0][31:0]);
    end
    chk("csr_rdata", csr_rdata, exp_rdata(csr_addr));
    chk("csr_illegal", csr_illegal, csr_en && (csr_addr < 12'h001 || csr_addr > 12'h003));
    chk("frm", frm, fcsr_m / 32);
  endtask

  task automatic model_update();
    int  sz = q.size();
    bit  push = bus.in_valid && (sz < 2) && !flush;
    bit  pop  = (sz > 0) && bus.wb_ready && !flush;
    int  fm, src;
    if (csr_en && csr_addr >= 12'h001 && csr_addr <= 12'h003 && csr_op != 2'd0) begin
      if (csr_addr == 12'h001) begin fm = 'h1f; src = csr_wdata[4:0]; end
      else if (csr_addr == 12'h002) begin fm = 'he0; src = csr_wdata[2:0] * 32; end
      else begin fm = 'hff; src = csr_wdata[7:0]; end
      if (csr_op == 2'd1) fcsr_m = (fcsr_m & ~fm & 'hff) | src;
      else if (csr_op == 2'd2) fcsr_m = fcsr_m | src;
      else fcsr_m = fcsr_m & ~src & 'hff;
    end
    if (push) fcsr_m = fcsr_m | bus.in_flags;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({bus.in_rd, bus.in_data});
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit
  // later, then the model advances with the coming rising edge.
  task automatic cycle();
    #1;
    check_outputs();
    model_update();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    fcsr_m = 0;
    drive(0, 0, 0, 0, 1, 0, 0, 0, 12'h003, 0);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_rd", bus.wb_rd, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_csr_rdata", csr_rdata, 0);
    chk("rst_csr_illegal", csr_illegal, 0);
    chk("rst_frm", frm, 0);
    @(negedge CLK);
    RSTn = 1'b1;

    // First push becomes visible one cycle later.
    drive(1, 5'd3, 32'h40400000, 5'h01, 1, 0, 0, 0, 12'h001, 0);
    cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 12'h001, 0);
    #1;
    chk("t1_wb_data", bus.wb_data, 32'h40400000);
    chk("t1_fflags", csr_rdata, 32'h01);
    cycle();

    // Back-pressure: three results with the sink stalled.
    drive(1, 5'd10, 32'hA, 0, 0, 0, 0, 0, 12'h001, 0); cycle();
    drive(1, 5'd11, 32'hB, 0, 0, 0, 0, 0, 12'h001, 0); cycle();
    drive(1, 5'd12, 32'hC, 0, 0, 0, 0, 0, 12'h001, 0);
    #1 chk("t2_full", bus.in_ready, 0);
    cycle();
    drive(1, 5'd12, 32'hC, 0, 1, 0, 0, 0, 12'h001, 0); cycle();
    drive(1, 5'd12, 32'hC, 0, 1, 0, 0, 0, 12'h001, 0); cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 12'h001, 0); cycle();
    #1 chk("t2_drained", bus.wb_valid, 0);

    // CSR clear of fflags in the same cycle as an NV-raising push.
    drive(1, 5'd4, 32'h7fc00000, 5'h10, 1, 0, 1, 2'd3, 12'h001, 32'h1f); cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 12'h001, 0);
    #1 chk("t3_fflags", csr_rdata, 32'h10);
    cycle();

    // fcsr write then fflags set.
    drive(0, 0, 0, 0, 1, 0, 1, 2'd1, 12'h003, 32'hE5); cycle();
    drive(0, 0, 0, 0, 1, 0, 1, 2'd2, 12'h001, 32'h02);
    #1 chk("t4_frm", frm, 3'd7);
    cycle();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 12'h003, 0);
    #1 chk("t4_fcsr", csr_rdata, 32'hE7);
    cycle();

    // Flush with two buffered entries and a flagged incoming result.
    drive(1, 5'd20, 32'h11, 0, 0, 0, 0, 0, 12'h001, 0); cycle();
    drive(1, 5'd21, 32'h22, 0, 0, 0, 0, 0, 12'h001, 0); cycle();
    drive(1, 5'd22, 32'h33, 5'h01, 0, 1, 0, 0, 12'h001, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h001, 0);
    #1 chk("t5_flushed", bus.wb_valid, 0);
    chk("t5_fflags", csr_rdata, 32'h07);
    cycle();

    // Illegal address: flagged and no state change.
    drive(0, 0, 0, 0, 0, 0, 1, 2'd1, 12'h004, 32'h00);
    #1 chk("t6_illegal", csr_illegal, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h003, 0);
    #1 chk("t6_fcsr", csr_rdata, 32'hE7);
    cycle();

    // Asynchronous reset mid-stream.
    drive(1, 5'd7, 32'h77, 5'h08, 0, 0, 0, 0, 12'h003, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12'h003, 0);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_wb_valid", bus.wb_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_fcsr", csr_rdata, 0);
    chk("arst_frm", frm, 0);
    q.delete();
    fcsr_m = 0;
    @(negedge CLK);
    RSTn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [11:0] a;
      a = 12'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) a = 12'($urandom);
      drive($urandom_range(0, 1), 5'($urandom), $urandom, 5'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0), 2'($urandom), a, $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
